// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding.
package program_loader_pkg;

  typedef enum logic [2:0] {
    LdrIdle,
    LdrAddr,
    LdrWait,
    LdrData,
    LdrRelease
  } ldr_state_e;

endpackage

// File: rtl/program_loader.sv
// Streams bytes into RAM over the shared bus while holding the CPU in reset,
// then releases it with a one-cycle restart pulse.
module program_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              c_mi,
  output logic              c_ri,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  import program_loader_pkg::*;

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] checksum_q;
  logic              done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LdrIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LdrIdle:    if (start) state_d = LdrAddr;
      LdrAddr:    state_d = LdrWait;
      LdrWait:    if (in_valid) state_d = LdrData;
      // count holds the pre-decrement value here; a start count of 0 runs 2^ADDR_W bytes.
      LdrData:    state_d = (count_q == ADDR_W'(1)) ? LdrRelease : LdrAddr;
      LdrRelease: state_d = LdrIdle;
      default:    state_d = LdrIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        LdrIdle: begin
          if (start) begin
            addr_q     <= base;
            count_q    <= len;
            checksum_q <= '0;
            done_q     <= 1'b0;
          end
        end
        LdrWait: begin
          if (in_valid) data_q <= in_data;
        end
        LdrData: begin
          checksum_q <= checksum_q + data_q;
          addr_q     <= addr_q + ADDR_W'(1);
          count_q    <= count_q - ADDR_W'(1);
        end
        LdrRelease: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Moore outputs: decoded from the registered state only.
  always_comb begin
    in_ready    = 1'b0;
    bus_out     = '0;
    bus_oe      = 1'b0;
    c_mi        = 1'b0;
    c_ri        = 1'b0;
    cpu_hold    = 1'b0;
    cpu_restart = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      LdrIdle: busy = 1'b0;
      LdrAddr: begin
        bus_oe   = 1'b1;
        bus_out  = DATA_W'(addr_q);
        c_mi     = 1'b1;
        cpu_hold = 1'b1;
      end
      LdrWait: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      LdrData: begin
        bus_oe   = 1'b1;
        bus_out  = data_q;
        c_ri     = 1'b1;
        cpu_hold = 1'b1;
      end
      LdrRelease: cpu_restart = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign done     = done_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: transaction-level write/latency model plus
// per-cycle bus-protocol checks.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] bus_out;
  logic       bus_oe, c_mi, c_ri, cpu_hold, cpu_restart, busy, done;
  logic [7:0] checksum;

  program_loader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .base       (base),
    .len        (len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .c_mi       (c_mi),
    .c_ri       (c_ri),
    .cpu_hold   (cpu_hold),
    .cpu_restart(cpu_restart),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [256];
  logic [7:0] tx [256];
  logic [7:0] mar = '0;
  logic [7:0] exp_addr_q [$];
  logic [7:0] exp_data_q [$];
  logic [7:0] last_wr_addr = '0;
  int         restart_cnt = 0;
  int         restart_cyc = 0;
  int         writes_seen = 0;
  int         last_lat = 0;
  logic       prev_restart = 1'b0;

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle compare: bus protocol invariants and RAM writes against the expected list.
  always @(negedge clk) begin
    if (rst_n) begin
      chk1("oe_without_hold", bus_oe & ~cpu_hold, 1'b0);
      chk1("mi_ri_together", c_mi & c_ri, 1'b0);
      chk1("ctl_without_oe", (c_mi | c_ri) & ~bus_oe, 1'b0);
      chk1("ready_outside_wait", in_ready & (bus_oe | ~cpu_hold), 1'b0);
      chk1("busy_state", busy, cpu_hold | cpu_restart);
      if (c_ri) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0h data=%0h required=none", mar, bus_out);
        end else begin
          chk8("wr_addr", mar, exp_addr_q.pop_front());
          chk8("wr_data", bus_out, exp_data_q.pop_front());
        end
        ram[mar]     = bus_out;
        last_wr_addr = mar;
        writes_seen++;
      end
      if (c_mi) mar = bus_out;
      if (cpu_restart) begin
        chk1("restart_width", prev_restart, 1'b0);
        restart_cnt++;
        restart_cyc = cyc;
      end
      prev_restart = cpu_restart;
    end else begin
      prev_restart = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input int stalls, output bit ok);
    int k;
    k  = stalls;
    ok = 1'b0;
    for (int bud = 0; bud < 40; bud++) begin
      if (in_ready) begin
        if (k > 0) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          k--;
        end else begin
          in_valid = 1'b1;
          in_data  = d;
          ok       = 1'b1;
        end
      end else begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      if (ok) return;
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout actual=no_accept required=accept_within_40");
  endtask

  task automatic expect_load(input logic [7:0] b, input int n, output logic [7:0] sum);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(b + 8'(i));
      exp_data_q.push_back(tx[i]);
      sum = sum + tx[i];
    end
  endtask

  task automatic run_load(input logic [7:0] b, input logic [7:0] l, input int smin,
                          input int smax, input bit poke);
    int n, tot, k, r0, s_cyc, bud;
    bit ok;
    logic [7:0] sum;
    n   = (l == 8'd0) ? 256 : int'(l);
    tot = 0;
    expect_load(b, n, sum);
    r0 = restart_cnt;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    len   = l;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    base  = 8'($urandom);
    len   = 8'($urandom);
    if (poke) begin
      fork
        begin
          repeat (3) @(negedge clk);
          start = 1'b1;
          base  = 8'h80;
          repeat (3) @(negedge clk);
          start = 1'b0;
        end
      join_none
    end
    for (int i = 0; i < n; i++) begin
      k   = int'($urandom_range(smax, smin));
      tot += k;
      send_byte(tx[i], k, ok);
      if (!ok) return;
    end
    in_valid = 1'b0;
    bud = 0;
    while (restart_cnt == r0 && bud < 20) begin
      @(negedge clk);
      bud++;
    end
    chk1("restart_seen", restart_cnt != r0, 1'b1);
    last_lat = restart_cyc - s_cyc;
    chk32("latency", last_lat, 3 * n + 1 + tot);
    chk8("checksum", checksum, sum);
    chk1("done", done, 1'b1);
    chk32("pending_writes", exp_addr_q.size(), 0);
    repeat (2) @(negedge clk);
    chk1("idle_after", busy, 1'b0);
    chk32("restart_once", restart_cnt - r0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, bud;
    bit ok;
    logic [7:0] sum;

    repeat (2) @(negedge clk);
    chk32("reset_outputs", 32'({bus_out, bus_oe, c_mi, c_ri, in_ready, cpu_hold, cpu_restart,
                               busy, done, checksum}), 32'd0);
    rst_n = 1'b1;

    // Basic load with in_valid always available.
    tx[0] = 8'h1E; tx[1] = 8'h2F; tx[2] = 8'hF0;
    run_load(8'h00, 8'd3, 0, 0, 1'b0);
    chk8("basic_ram0", ram[0], 8'h1E);
    chk8("basic_ram1", ram[1], 8'h2F);
    chk8("basic_ram2", ram[2], 8'hF0);
    chk8("basic_checksum", checksum, 8'h3D);
    chk32("basic_latency", last_lat, 10);

    // Backpressure: four WAIT stalls before each byte.
    run_load(8'h00, 8'd3, 4, 4, 1'b0);
    chk32("bp_latency", last_lat, 22);

    // Start pulsed mid-load must be ignored.
    tx[0] = 8'hA5; tx[1] = 8'h5A; tx[2] = 8'h33;
    run_load(8'h20, 8'd3, 0, 0, 1'b1);
    chk32("poke_latency", last_lat, 10);
    chk8("poke_ram22", ram[8'h22], 8'h33);

    // Address wrap.
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    run_load(8'hFE, 8'd3, 0, 1, 1'b0);
    chk8("wrap_fe", ram[8'hFE], 8'h11);
    chk8("wrap_ff", ram[8'hFF], 8'h22);
    chk8("wrap_00", ram[8'h00], 8'h33);

    // Randomized loads.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
      run_load(8'($urandom), 8'($urandom_range(8, 1)), 0, 3, 1'b0);
    end

    // len=0 means a full 256-byte load.
    for (int i = 0; i < 256; i++) tx[i] = 8'($urandom);
    run_load(8'h10, 8'd0, 0, 0, 1'b0);
    chk8("len0_last_addr", last_wr_addr, 8'h0F);

    // Asynchronous reset after the first byte is written.
    for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
    expect_load(8'h40, 4, sum);
    w0 = writes_seen;
    @(negedge clk);
    start = 1'b1;
    base  = 8'h40;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    send_byte(tx[0], 0, ok);
    bud = 0;
    while (writes_seen == w0 && bud < 10) begin
      @(negedge clk);
      bud++;
    end
    chk32("reset_first_write", writes_seen - w0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk32("midload_reset_outputs", 32'({bus_out, bus_oe, c_mi, c_ri, in_ready, cpu_hold,
                                       cpu_restart, busy, done, checksum}), 32'd0);
    chk8("reset_keeps_ram", ram[8'h40], tx[0]);
    exp_addr_q.delete();
    exp_data_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
    run_load(8'h60, 8'd5, 0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Bus-writing front end that fills RAM before the CPU runs. The CPU side only reads RAM (fetch/load); this block is the writer on the same shared 8-bit bus.
- Accepts a byte stream over valid/ready and writes each byte to consecutive RAM addresses. It drives the bus plus the MAR-in and RAM-in controls.
- Holds the CPU in reset while it owns the bus, then releases it with a one-cycle restart pulse.

Parameters:
- DATA_W, 8, bus/data width.
- ADDR_W, 8, RAM address width; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- base  in  ADDR_W  first RAM address; latched on accepted start.
- len  in  ADDR_W  byte count; latched on accepted start; 0 means 2^ADDR_W bytes.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- bus_out  out  DATA_W  value for the shared bus; gated by a tristate_buffer controlled by bus_oe.
- bus_oe  out  1  loader drives the bus.
- c_mi  out  1  MAR load enable (OR-ed with CPU c_mi).
- c_ri  out  1  RAM write enable (OR-ed with CPU c_ri).
- cpu_hold  out  1  high while loading; holds CPU registers, PC and cycle counter in reset.
- cpu_restart  out  1  one-cycle pulse after the final write.
- busy  out  1  high in any state except IDLE.
- done  out  1  sticky; set in RELEASE, cleared on the next accepted start.
- checksum  out  DATA_W  running mod-2^DATA_W sum of written bytes; cleared on accepted start.

Behaviour:
- Reset (async, active-low) forces state IDLE and drives every output to 0.
  - Includes bus_out, bus_oe, c_mi, c_ri, in_ready, cpu_hold, cpu_restart, busy, done, checksum.
  - Internal addr, count and data registers also clear to 0.
  - Reset mid-load abandons the load; RAM writes already performed remain.
- States: IDLE, ADDR, WAIT, DATA, RELEASE. Outputs are decoded from the registered state only (Moore). Bus consumers capture on the same rising edge.
- IDLE: all control outputs 0. start=1 latches base→addr and len→count, clears checksum and done, then moves to ADDR.
- ADDR: bus_oe=1, bus_out=addr, c_mi=1, cpu_hold=1. Next state is WAIT.
- WAIT: in_ready=1, cpu_hold=1, bus_oe=0.
  - On in_valid&in_ready, capture in_data and move to DATA.
  - Otherwise stay in WAIT, with no timeout.
- DATA: bus_oe=1, bus_out=captured byte, c_ri=1, cpu_hold=1. On exit:
  - checksum += byte;
  - addr += 1, wrapping;
  - count -= 1.
  - Next state is RELEASE if the pre-decrement count == 1, else ADDR.
  - len=0 therefore yields exactly 2^ADDR_W writes.
- RELEASE: cpu_hold=0, cpu_restart=1 for exactly one cycle, done set. Next state is IDLE.
- Cost per byte: minimum 3 cycles (ADDR, WAIT, DATA). Added latency equals in_valid stall cycles.
- in_ready is asserted only in WAIT, so at most one byte is in flight and no stream data is dropped.
- start outside IDLE is ignored. start held high across RELEASE begins a new load from IDLE on the following cycle.
- bus_oe, c_mi and c_ri are never high in the same cycle as each other except bus_oe with c_mi (ADDR) or bus_oe with c_ri (DATA).
- bus_oe=0 whenever cpu_hold=0, so there is no bus contention with the CPU.

Decomposition:
- Loader state encodings go into the shared parameters.v alongside the CPU state codes: `LDR_IDLE, `LDR_ADDR, `LDR_WAIT, `LDR_DATA, `LDR_RELEASE.
- No sub-module. Bus gating reuses the existing tristate_buffer at the integration level; the FSM, address and count registers stay in one module.

Test Plan:
- Basic load: base=0x00, len=3, stream 0x1E,0x2F,0xF0 with in_valid always high.
  - RAM[0..2] = 1E,2F,F0; checksum=0x3D; done=1.
  - cpu_restart pulses once, 10 cycles after start.
  - cpu_hold is high throughout.
- Backpressure: same load with in_valid low for 4 cycles before each byte.
  - Each byte accepted exactly once; total 22 cycles; in_ready high only in WAIT.
- Wrap and len=0:
  - base=0xFE, len=3 → writes at addresses FE, FF, 00.
  - base=0x10, len=0 → 256 writes, last at 0x0F; checksum matches the model.
- Start while busy: pulse start with base=0x80 mid-load → ignored; original addresses continue; no restart until the first load ends.
- Async reset mid-load: assert reset after byte 1 is written, off-edge.
  - All outputs drop to 0 immediately; bus released; state IDLE.
  - A fresh start then works normally.
- Bus exclusivity: monitor the whole run. bus_oe=1 only with cpu_hold=1; c_mi and c_ri never high in the same cycle.
